// File: rtl/pipe_dest_tracker_pkg.sv
// Shared definitions for the operand-forwarding destination tracker:
// instruction result-kind codes and the default register-number width.
package pipe_dest_tracker_pkg;

    localparam int REG_AW_DEF = 5;

    // When an instruction's result becomes available to forwarding.
    typedef enum logic [1:0] {
        KIND_ALU   = 2'b00,  // ready in EXE
        KIND_LOAD  = 2'b01,  // ready in MEM once load data returns
        KIND_MULTI = 2'b10,  // ready in EXE once mul/div reports done
        KIND_NOWB  = 2'b11   // writes no register
    } kind_e;

endpackage

// File: rtl/pipe_dest_tracker_stage_reg.sv
// One pipeline stage register for the destination tracker.
// Holds valid, dest, kind and a completion latch; derives ready_go/allowin.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            kill contents next cycle (overrides capture)
//   in_valid         upstream offers an instruction this cycle
//   in_dest, in_kind upstream instruction fields
//   done             completion event for WAIT_KIND instructions
//   next_allowin     downstream stage can accept
//   valid, dest,     stage state (dest is 0 while the stage is empty)
//   kind, done_latched
//   allowin          this stage can accept this cycle
//   advance          held instruction leaves this cycle
module pipe_dest_tracker_stage_reg
    import pipe_dest_tracker_pkg::*;
#(
    parameter int    REG_AW    = REG_AW_DEF,
    parameter kind_e WAIT_KIND = KIND_MULTI
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] in_dest,
    input  kind_e             in_kind,
    input  logic              done,
    input  logic              next_allowin,
    output logic              valid,
    output logic [REG_AW-1:0] dest,
    output kind_e             kind,
    output logic              done_latched,
    output logic              allowin,
    output logic              advance
);

    logic waiting;
    logic ready_go;

    // A done pulse in the same cycle releases the stage immediately.
    assign waiting  = (kind == WAIT_KIND) && !done_latched && !done;
    assign ready_go = !waiting;
    assign allowin  = !valid || (ready_go && next_allowin);
    assign advance  = valid && ready_go && next_allowin;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid        <= 1'b0;
            dest         <= '0;
            kind         <= KIND_ALU;
            done_latched <= 1'b0;
        end else if (in_valid && allowin) begin
            valid        <= 1'b1;
            dest         <= in_dest;
            kind         <= in_kind;
            done_latched <= 1'b0;
        end else if (advance) begin
            valid        <= 1'b0;
            dest         <= '0;
            kind         <= KIND_ALU;
            done_latched <= 1'b0;
        end else if (valid && kind == WAIT_KIND && done) begin
            done_latched <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_dest_tracker.sv
// Producer side of operand forwarding: tracks dest/valid/finish through
// EXE (pipe3), MEM (pipe4), WB (pipe5) and raises id_stall on RAW against
// an unfinished producer. Optional stall counter: PIPE_STALL_CNT_EN.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   id_valid, id_dest,       ID instruction, its kind and sources
//   id_kind, id_rs, id_rt
//   multi_done, mem_data_ok  completion events for EXE mul/div, MEM load
//   flush                    kill EXE and MEM
//   exe_allowin, id_stall    ID handshake
//   pipeN_valid/finish       per-stage state for forwarding select
//   dest_exec/mem/wb         stage destinations (0 when no writer)
//   stall_cnt                id_stall cycle count (PIPE_STALL_CNT_EN)
module pipe_dest_tracker
    import pipe_dest_tracker_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
`ifdef PIPE_STALL_CNT_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [1:0]        id_kind,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              multi_done,
    input  logic              mem_data_ok,
    input  logic              flush,
    output logic              exe_allowin,
    output logic              id_stall,
    output logic              pipe3_valid,
    output logic              pipe3_finish,
    output logic              pipe4_valid,
    output logic              pipe4_finish,
    output logic              pipe5_valid,
    output logic              pipe5_finish,
    output logic [REG_AW-1:0] dest_exec,
    output logic [REG_AW-1:0] dest_mem,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic [REG_AW-1:0] dest_wb
);

    kind_e             cap_kind;
    logic [REG_AW-1:0] cap_dest;
    kind_e             exe_kind;
    kind_e             mem_kind;
    logic              exe_latched;
    logic              mem_latched;
    logic              exe_advance;
    logic              mem_advance;
    logic              mem_allowin;
    logic              id_go;
    logic              rs_hit;
    logic              rt_hit;

    assign cap_kind = kind_e'(id_kind);
    assign cap_dest = (cap_kind == KIND_NOWB) ? '0 : id_dest;
    assign id_go    = id_valid && !id_stall;

    pipe_dest_tracker_stage_reg #(
        .REG_AW    (REG_AW),
        .WAIT_KIND (KIND_MULTI)
    ) u_exe (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (id_go),
        .in_dest      (cap_dest),
        .in_kind      (cap_kind),
        .done         (multi_done),
        .next_allowin (mem_allowin),
        .valid        (pipe3_valid),
        .dest         (dest_exec),
        .kind         (exe_kind),
        .done_latched (exe_latched),
        .allowin      (exe_allowin),
        .advance      (exe_advance)
    );

    // WB always accepts, so MEM only waits on its own load data.
    pipe_dest_tracker_stage_reg #(
        .REG_AW    (REG_AW),
        .WAIT_KIND (KIND_LOAD)
    ) u_mem (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (exe_advance),
        .in_dest      (dest_exec),
        .in_kind      (exe_kind),
        .done         (mem_data_ok),
        .next_allowin (1'b1),
        .valid        (pipe4_valid),
        .dest         (dest_mem),
        .kind         (mem_kind),
        .done_latched (mem_latched),
        .allowin      (mem_allowin),
        .advance      (mem_advance)
    );

    // A flushed MEM instruction must not reach WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe5_valid <= 1'b0;
            dest_wb     <= '0;
        end else if (mem_advance && !flush) begin
            pipe5_valid <= 1'b1;
            dest_wb     <= dest_mem;
        end else begin
            pipe5_valid <= 1'b0;
            dest_wb     <= '0;
        end
    end

    assign pipe3_finish = pipe3_valid &&
                          (exe_kind == KIND_ALU  ||
                           exe_kind == KIND_NOWB ||
                           exe_latched || multi_done);
    assign pipe4_finish = pipe4_valid &&
                          (mem_kind != KIND_LOAD ||
                           mem_latched || mem_data_ok);
    assign pipe5_finish = pipe5_valid;

    function automatic logic src_hit(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] d3,
        input logic              busy3,
        input logic [REG_AW-1:0] d4,
        input logic              busy4
    );
        return (src != '0) &&
               ((busy3 && src == d3) || (busy4 && src == d4));
    endfunction

    assign rs_hit = src_hit(id_rs,
                            dest_exec, pipe3_valid && !pipe3_finish,
                            dest_mem,  pipe4_valid && !pipe4_finish);
    assign rt_hit = src_hit(id_rt,
                            dest_exec, pipe3_valid && !pipe3_finish,
                            dest_mem,  pipe4_valid && !pipe4_finish);
    assign id_stall = id_valid && (rs_hit || rt_hit);

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (id_stall) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Scoreboard bench for pipe_dest_tracker: instruction-flow reference model,
// directed scenarios followed by randomized traffic.
module tb_pipe_dest_tracker;

    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LD   = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;
    localparam logic [1:0] K_NOWB = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_dest;
    logic [1:0] id_kind;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       multi_done;
    logic       mem_data_ok;
    logic       flush;
    logic       exe_allowin;
    logic       id_stall;
    logic       pipe3_valid, pipe3_finish;
    logic       pipe4_valid, pipe4_finish;
    logic       pipe5_valid, pipe5_finish;
    logic [4:0] dest_exec, dest_mem, dest_wb;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_dest_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_dest      (id_dest),
        .id_kind      (id_kind),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .multi_done   (multi_done),
        .mem_data_ok  (mem_data_ok),
        .flush        (flush),
        .exe_allowin  (exe_allowin),
        .id_stall     (id_stall),
        .pipe3_valid  (pipe3_valid),
        .pipe3_finish (pipe3_finish),
        .pipe4_valid  (pipe4_valid),
        .pipe4_finish (pipe4_finish),
        .pipe5_valid  (pipe5_valid),
        .pipe5_finish (pipe5_finish),
        .dest_exec    (dest_exec),
        .dest_mem     (dest_mem),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .dest_wb      (dest_wb)
    );

    typedef struct packed {
        logic        allowin;
        logic        stall;
        logic        v3, f3, v4, f4, v5, f5;
        logic [4:0]  d3, d4, d5;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model: one instruction record per stage.
    // "have" = result already available to forwarding.
    logic       mv [3:5];
    logic [4:0] mdst [3:5];
    logic [1:0] mk [3:5];
    logic       mh [3:5];
    int         mcnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] s,
                                 input logic f3, input logic f4);
        return (s != 0) &&
               ((mv[3] && !f3 && mdst[3] == s) ||
                (mv[4] && !f4 && mdst[4] == s));
    endfunction

    task automatic model_clear();
        for (int i = 3; i <= 5; i++) begin
            mv[i] = 0; mdst[i] = 0; mk[i] = K_ALU; mh[i] = 0;
        end
    endtask

    // Apply one cycle of inputs, push the expected outputs, advance model.
    task automatic step(input logic idv, input logic [1:0] kd,
                        input logic [4:0] dst, input logic [4:0] rs,
                        input logic [4:0] rt, input logic mdr,
                        input logic okr, input logic fl,
                        input logic rst, output logic moved);
        logic md, ok, f3, f4, stl, go3, go4, lv3, lv4, alw;
        exp_t e;
        // completion events only when an instruction is waiting on them
        md = mdr && mv[3] && mk[3] == K_MUL && !mh[3];
        ok = okr && mv[4] && mk[4] == K_LD && !mh[4];
        id_valid = idv; id_kind = kd; id_dest = dst;
        id_rs = rs; id_rt = rt;
        multi_done = md; mem_data_ok = ok;
        flush = fl; reset = rst;
        f3  = mv[3] && (mh[3] || md);
        f4  = mv[4] && (mh[4] || ok);
        stl = idv && (hit(rs, f3, f4) || hit(rt, f3, f4));
        go3 = mk[3] != K_MUL || mh[3] || md;
        go4 = mk[4] != K_LD || mh[4] || ok;
        lv4 = mv[4] && go4;
        lv3 = mv[3] && go3 && (!mv[4] || lv4);
        alw = !mv[3] || lv3;
        e.allowin = alw; e.stall = stl;
        e.v3 = mv[3]; e.f3 = f3;
        e.v4 = mv[4]; e.f4 = f4;
        e.v5 = mv[5]; e.f5 = mv[5];
        e.d3 = mv[3] ? mdst[3] : 5'd0;
        e.d4 = mv[4] ? mdst[4] : 5'd0;
        e.d5 = mv[5] ? mdst[5] : 5'd0;
        e.cnt = mcnt;
        q.push_back(e);
        moved = idv && alw && !stl && !fl && !rst;
        if (rst) begin
            model_clear();
            mcnt = 0;
        end else begin
            if (stl) mcnt++;
            mv[5] = lv4 && !fl; mdst[5] = mdst[4];
            if (fl) begin
                mv[3] = 0; mv[4] = 0;
            end else begin
                if (lv3) begin
                    mv[4] = 1; mdst[4] = mdst[3]; mk[4] = mk[3];
                    mh[4] = (mk[3] != K_LD);
                end else if (lv4) begin
                    mv[4] = 0;
                end else if (ok) begin
                    mh[4] = 1;
                end
                if (idv && alw && !stl) begin
                    mv[3] = 1; mk[3] = kd;
                    mdst[3] = (kd == K_NOWB) ? 5'd0 : dst;
                    mh[3] = (kd == K_ALU || kd == K_NOWB);
                end else if (lv3) begin
                    mv[3] = 0;
                end else if (md) begin
                    mh[3] = 1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("exe_allowin", 32'(exe_allowin), 32'(e.allowin));
                chk("id_stall", 32'(id_stall), 32'(e.stall));
                chk("pipe3_valid", 32'(pipe3_valid), 32'(e.v3));
                chk("pipe3_finish", 32'(pipe3_finish), 32'(e.f3));
                chk("pipe4_valid", 32'(pipe4_valid), 32'(e.v4));
                chk("pipe4_finish", 32'(pipe4_finish), 32'(e.f4));
                chk("pipe5_valid", 32'(pipe5_valid), 32'(e.v5));
                chk("pipe5_finish", 32'(pipe5_finish), 32'(e.f5));
                chk("dest_exec", 32'(dest_exec), 32'(e.d3));
                chk("dest_mem", 32'(dest_mem), 32'(e.d4));
                chk("dest_wb", 32'(dest_wb), 32'(e.d5));
`ifdef PIPE_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, e.cnt);
`endif
                cyc++;
            end
        end
    end

    typedef struct packed {
        logic       idv;
        logic [1:0] kd;
        logic [4:0] dst, rs, rt;
        logic       md, ok, fl, rst;
    } row_t;

    row_t tbl[$];

    function automatic row_t r(input logic idv, input logic [1:0] kd,
                               input int dst, input int rs,
                               input int rt, input logic md,
                               input logic ok, input logic fl,
                               input logic rst);
        row_t x;
        x.idv = idv; x.kd = kd;
        x.dst = 5'(dst); x.rs = 5'(rs); x.rt = 5'(rt);
        x.md = md; x.ok = ok; x.fl = fl; x.rst = rst;
        return x;
    endfunction

    initial begin
        logic       mvd;
        logic       hold;
        logic       c_idv;
        logic [1:0] c_kd;
        logic [4:0] c_dst, c_rs, c_rt;

        model_clear();
        mcnt = 0;
        id_valid = 0; id_kind = 0; id_dest = 0; id_rs = 0; id_rt = 0;
        multi_done = 0; mem_data_ok = 0; flush = 0; reset = 1;
        @(posedge clk); @(posedge clk); #1;

        // reset state, then ALU r3 followed by a reader of r3
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(r(1, K_ALU, 3, 1, 2, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 4, 3, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        // load r5 then use r5, data returns after one MEM wait
        tbl.push_back(r(1, K_LD,  5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 6, 5, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 6, 5, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 6, 0, 5, 0, 1, 0, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        // mul r7, dependent stalls four cycles, then done
        tbl.push_back(r(1, K_MUL, 7, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(r(1, K_ALU, 8, 7, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 8, 7, 0, 1, 0, 0, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        // r0 never matches; no-write kind gives dest 0
        tbl.push_back(r(1, K_LD,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_NOWB, 9, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 2, 9, 0, 0, 1, 0, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        // flush with EXE, MEM, WB busy and ID offering
        tbl.push_back(r(1, K_ALU, 10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 11, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 12, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 13, 0, 0, 0, 0, 1, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));
        // six stall cycles then reset mid-stall
        tbl.push_back(r(1, K_MUL, 8, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(r(1, K_ALU, 4, 0, 8, 0, 0, 0, 0));
        tbl.push_back(r(1, K_ALU, 4, 0, 8, 0, 0, 0, 1));
        tbl.push_back(r(0, K_ALU, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i])
            step(tbl[i].idv, tbl[i].kd, tbl[i].dst, tbl[i].rs,
                 tbl[i].rt, tbl[i].md, tbl[i].ok, tbl[i].fl,
                 tbl[i].rst, mvd);

        // randomized traffic; ID holds its instruction until it moves
        hold = 0;
        c_idv = 0; c_kd = 0; c_dst = 0; c_rs = 0; c_rt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                c_idv = ($urandom_range(0, 3) != 0);
                c_kd  = 2'($urandom_range(0, 3));
                c_dst = 5'($urandom_range(0, 4));
                c_rs  = 5'($urandom_range(0, 4));
                c_rt  = 5'($urandom_range(0, 4));
            end
            step(c_idv, c_kd, c_dst, c_rs, c_rt,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 200) == 0), mvd);
            hold = c_idv && !mvd;
        end

        step(0, K_ALU, 0, 0, 0, 0, 0, 0, 0, mvd);
        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
